out_digest: RTL and testbench

Scrolling display formatter for the 128-bit MD5 digest. It shows a 6-hex-digit window of the digest on six 5-bit digit codes for the downstream seven-segment driver. Left and right push-buttons move the window one byte (two hex digits) at a time. It sits after the MD5 core's digest register, and `start` gates it until the digest is valid.

---
 rtl/out_digest_pkg.sv | 8 +
 rtl/out_digest_btn_edge.sv | 12 +
 rtl/out_digest.sv | 60 ++++++
 tb/tb_out_digest.sv | 136 +++++++++++++
 4 files changed

// File: rtl/out_digest_pkg.sv
// out_digest_pkg: shared sizes and the digit-code type for the digest display formatter.
package out_digest_pkg;
    localparam int NIBBLES    = 32;
    localparam int WIN_DIGITS = 6;
    localparam int OFS_MAX    = 13;
    localparam int CODE_W     = 5;
    typedef logic [CODE_W-1:0] code_t;
endpackage

// File: rtl/out_digest_btn_edge.sv
// btn_edge: registered rising-edge detector for a push-button level.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);
    logic prev;
    always_ff @(posedge clk)
        prev <= !rst ? 1'b0 : level;
    assign pulse = level & ~prev;
endmodule

// File: rtl/out_digest.sv
// out_digest: scrolling 6-hex-digit window over the MD5 digest, moved a byte per button press.
// Define OUT_DIGEST_WRAP_EN to make the offset wrap at 0/13 instead of saturating.
module out_digest
    import out_digest_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   data_in,
    input  logic                   left_shift,
    input  logic                   right_shift,
    output logic [CODE_W-1:0]      seg,
    output logic [CODE_W-1:0]      seg1,
    output logic [CODE_W-1:0]      seg2,
    output logic [CODE_W-1:0]      seg3,
    output logic [CODE_W-1:0]      seg4,
    output logic [CODE_W-1:0]      seg5
);
    logic       left_edge, right_edge;
    logic [3:0] ofs, ofs_nxt, ofs_up, ofs_dn;
    logic [4*WIN_DIGITS-1:0] win;
    code_t      digits [WIN_DIGITS];

    btn_edge u_left  (.clk(clk), .rst(rst), .level(left_shift),  .pulse(left_edge));
    btn_edge u_right (.clk(clk), .rst(rst), .level(right_shift), .pulse(right_edge));

`ifdef OUT_DIGEST_WRAP_EN
    assign ofs_up = (ofs == 4'(OFS_MAX)) ? 4'd0 : ofs + 4'd1;
    assign ofs_dn = (ofs == 4'd0) ? 4'(OFS_MAX) : ofs - 4'd1;
`else
    assign ofs_up = (ofs == 4'(OFS_MAX)) ? ofs : ofs + 4'd1;
    assign ofs_dn = (ofs == 4'd0) ? ofs : ofs - 4'd1;
`endif

    // Simultaneous left and right edges cancel out.
    always_comb
        ofs_nxt = !start ? ofs :
                  (left_edge && !right_edge) ? ofs_up :
                  (right_edge && !left_edge) ? ofs_dn : ofs;

    always_ff @(posedge clk)
        ofs <= !rst ? 4'd0 : ofs_nxt;

    assign win = 24'(data_in >> {ofs, 3'b000});

    always_ff @(posedge clk) begin
        if (!rst)
            digits <= '{default: '0};
        else if (start)
            for (int k = 0; k < WIN_DIGITS; k++)
                digits[k] <= {1'b0, win[4*k +: 4]};
    end

    assign seg  = digits[0];
    assign seg1 = digits[1];
    assign seg2 = digits[2];
    assign seg3 = digits[3];
    assign seg4 = digits[4];
    assign seg5 = digits[5];
endmodule

// File: tb/tb_out_digest.sv
// tb_out_digest: directed test-plan scenarios plus random stimulus against a behavioural window model.
module tb_out_digest;
    localparam logic [127:0] DIGEST = 128'hf9d971aef6e7183fd0b0d1a06c7e530c;

    logic         clk = 0;
    logic         rst = 0;
    logic         start = 0;
    logic [127:0] data_in = DIGEST;
    logic         left_shift = 0, right_shift = 0;
    logic [4:0]   seg, seg1, seg2, seg3, seg4, seg5;

    int errors = 0, checks = 0;
    int m_ofs = 0;
    bit m_pl = 0, m_pr = 0;
    logic [4:0] m_dig [6] = '{default: '0};
    logic [29:0] snap;

    out_digest dut (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in),
        .left_shift(left_shift), .right_shift(right_shift),
        .seg(seg), .seg1(seg1), .seg2(seg2), .seg3(seg3), .seg4(seg4), .seg5(seg5)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] nib(input logic [127:0] d, input int idx);
        return 4'((d >> (4 * idx)) & 128'hf);
    endfunction

    function automatic logic [29:0] shown();
        return {seg5, seg4, seg3, seg2, seg1, seg};
    endfunction

    function automatic logic [29:0] model_win();
        return {m_dig[5], m_dig[4], m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
    endfunction

    task automatic step(input bit s, input bit l, input bit r, input bit rn);
        bit le, re;
        start = s; left_shift = l; right_shift = r; rst = rn;
        @(posedge clk);
        if (!rn) begin
            m_ofs = 0; m_pl = 0; m_pr = 0; m_dig = '{default: '0};
        end else begin
            le = l && !m_pl;
            re = r && !m_pr;
            if (s) begin
                for (int k = 0; k < 6; k++) m_dig[k] = {1'b0, nib(data_in, 2 * m_ofs + k)};
                if (le && !re) begin
`ifdef OUT_DIGEST_WRAP_EN
                    m_ofs = (m_ofs == 13) ? 0 : m_ofs + 1;
`else
                    m_ofs = (m_ofs < 13) ? m_ofs + 1 : 13;
`endif
                end else if (re && !le) begin
`ifdef OUT_DIGEST_WRAP_EN
                    m_ofs = (m_ofs == 0) ? 13 : m_ofs - 1;
`else
                    m_ofs = (m_ofs > 0) ? m_ofs - 1 : 0;
`endif
                end
            end
            m_pl = l; m_pr = r;
        end
        #1;
        check("win_model", 32'(shown()), 32'(model_win()));
    endtask

    task automatic press(input bit s, input bit l, input bit r);
        step(s, l, r, 1);
        step(s, 0, 0, 1);
    endtask

    initial begin
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("reset_zero", 32'(shown()), 32'h0);
        step(1, 0, 0, 1);
        check("first_load", 32'(shown()), 32'({5'h07, 5'h0e, 5'h05, 5'h03, 5'h00, 5'h0c}));
        for (int i = 0; i < 8; i++) press(1, 1, 0);
        for (int i = 0; i < 2; i++) press(1, 0, 1);
        check("ofs6_win", 32'(shown()), 32'({5'h03, 5'h0f, 5'h0d, 5'h00, 5'h0b, 5'h00}));
        check("ofs6_seg4", 32'(seg4), 32'h0f);
        snap = shown();
        for (int i = 0; i < 5; i++) press(0, 1, 0);
        for (int i = 0; i < 2; i++) press(0, 0, 1);
        check("frozen_win", 32'(shown()), 32'(snap));
        check("frozen_seg4", 32'(seg4), 32'h0f);
        step(0, 0, 0, 0);
        check("rst_seg1", 32'(seg1), 32'h0);
        check("rst_all", 32'(shown()), 32'h0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("rst_hold", 32'(shown()), 32'h0);
        step(1, 0, 0, 1);
        for (int i = 0; i < 20; i++) press(1, 1, 0);
        check("sat_hi", 32'(shown()), 32'({5'h0f, 5'h09, 5'h0d, 5'h09, 5'h07, 5'h01}));
        press(1, 1, 0);
`ifdef OUT_DIGEST_WRAP_EN
        check("wrap_hi", 32'(shown()), 32'({5'h07, 5'h0e, 5'h05, 5'h03, 5'h00, 5'h0c}));
`else
        check("sat_hi2", 32'(shown()), 32'({5'h0f, 5'h09, 5'h0d, 5'h09, 5'h07, 5'h01}));
`endif
        step(1, 0, 0, 0);
        step(1, 0, 0, 1);
        for (int i = 0; i < 10; i++) step(1, 1, 0, 1);
        step(1, 0, 0, 1);
        check("hold_one_step", 32'(shown()), 32'({5'h06, 5'h0c, 5'h07, 5'h0e, 5'h05, 5'h03}));
        press(1, 1, 1);
        step(1, 0, 0, 1);
        check("both_nochange", 32'(shown()), 32'({5'h06, 5'h0c, 5'h07, 5'h0e, 5'h05, 5'h03}));
        press(1, 0, 1);
        press(1, 0, 1);
`ifdef OUT_DIGEST_WRAP_EN
        check("wrap_lo", 32'(shown()), 32'({5'h0f, 5'h09, 5'h0d, 5'h09, 5'h07, 5'h01}));
`else
        check("sat_lo", 32'(shown()), 32'({5'h07, 5'h0e, 5'h05, 5'h03, 5'h00, 5'h0c}));
`endif
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0)
                data_in = {$urandom, $urandom, $urandom, $urandom};
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 60) != 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
